// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-unit constants and state encoding.
package riscv_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} ifu_state_e;
endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC register and single-outstanding-request fetch FSM feeding the decode register.
module ifu_fetch
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     Inst,
  output logic [XLEN-1:0] pc_out,
  output logic            inst_err
);
  ifu_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_out_q, pc_out_d;
  logic [31:0] inst_q, inst_d;
  logic err_q, err_d, drop_q, drop_d;
  assign imem_req_valid = !rst && state_q == S_REQ && !redirect_valid;
  assign imem_addr = pc_q;
  assign inst_valid = state_q == S_OUT;
  assign Inst = inst_q;
  assign pc_out = pc_out_q;
  assign inst_err = err_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    drop_d = drop_q;
    inst_d = inst_q;
    pc_out_d = pc_out_q;
    err_d = err_q;
    case (state_q)
      S_REQ: state_d = imem_req_valid && imem_req_ready ? S_WAIT : S_REQ;
      S_WAIT: begin
        // a response landing with a pending or same-cycle redirect belongs to the old stream
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          state_d = drop_q || redirect_valid ? S_REQ : S_OUT;
          if (!drop_q && !redirect_valid) {inst_d, err_d, pc_out_d} = {imem_rsp_data, imem_rsp_err, pc_q};
        end else begin
          drop_d = drop_q || redirect_valid;
        end
      end
      S_OUT: begin
        state_d = inst_ready || redirect_valid ? S_REQ : S_OUT;
        pc_d = inst_ready ? pc_q + XLEN'(4) : pc_q;
      end
      default: state_d = S_REQ;
    endcase
    if (redirect_valid) pc_d = {redirect_pc[XLEN-1:2], 2'b00};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q <= RESET_PC;
      drop_q <= 1'b0;
      inst_q <= NOP_INST;
      pc_out_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      drop_q <= drop_d;
      inst_q <= inst_d;
      pc_out_q <= pc_out_d;
      err_q <= err_d;
    end
  end
endmodule
